// File: rtl/prim_ram_1p_init_pkg.sv
// Types for the initialising single-port RAM front end.
// Re-exports the macro config type next to the init FSM states.
package prim_ram_1p_init_pkg;

    typedef prim_ram_1p_pkg::ram_1p_cfg_t ram_1p_cfg_t;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        INIT  = 2'd1,
        READY = 2'd2
    } init_state_e;

endpackage

// File: rtl/prim_ram_1p_pkg.sv
// Shared types for the single-port RAM storage primitive.
// Holds the macro configuration bundle forwarded from the SoC.
package prim_ram_1p_pkg;

    typedef struct packed {
        logic       ram_cfg_en;
        logic [3:0] ram_cfg;
        logic       rf_cfg_en;
        logic [3:0] rf_cfg;
    } ram_1p_cfg_t;

    localparam ram_1p_cfg_t RAM_1P_CFG_DEFAULT = '0;

endpackage

// File: rtl/prim_ram_1p.sv
// Behavioural single-port RAM macro with grouped bit-write masks.
// One-cycle registered read; read data only changes on a read.
module prim_ram_1p
    import prim_ram_1p_pkg::*;
#(
    parameter int Width           = 32,
    parameter int Depth           = 128,
    parameter int DataBitsPerMask = 1,
    localparam int Aw             = $clog2(Depth)
) (
    input  logic             i_clk,
    input  logic             i_req,
    input  logic             i_write,
    input  logic [Aw-1:0]    i_addr,
    input  logic [Width-1:0] i_wdata,
    input  logic [Width-1:0] i_wmask,
    output logic [Width-1:0] o_rdata,
    input  ram_1p_cfg_t      i_cfg
);

    localparam int MaskW = Width / DataBitsPerMask;

    logic [Width-1:0] r_mem [Depth];
    logic [Width-1:0] r_rdata;
    logic [MaskW-1:0] w_gmask;
    logic             w_unused_cfg;

    // Only the lowest bit of each mask group selects the group.
    always_comb begin
        w_gmask = '0;
        for (int k = 0; k < MaskW; k++) begin
            w_gmask[k] = i_wmask[k*DataBitsPerMask];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_req) begin
            if (i_write) begin
                for (int k = 0; k < MaskW; k++) begin
                    if (w_gmask[k]) begin
                        r_mem[i_addr][k*DataBitsPerMask +: DataBitsPerMask] <=
                            i_wdata[k*DataBitsPerMask +: DataBitsPerMask];
                    end
                end
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata      = r_rdata;
    assign w_unused_cfg = ^{i_cfg, i_wmask};

endmodule

// File: rtl/prim_ram_1p_init.sv
// Single-port RAM front end: req/gnt, rvalid, optional output
// register, hardware init sweep and out-of-range flagging.
module prim_ram_1p_init
    import prim_ram_1p_init_pkg::*;
#(
    parameter int               Width           = 32,
    parameter int               Depth           = 128,
    parameter int               DataBitsPerMask = 1,
    parameter int               OutputReg       = 0,
    parameter int               InitOnReset     = 1,
    parameter logic [Width-1:0] InitValue       = '0,
    localparam int              Aw              = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             init_req_i,
    output logic             init_done_o,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic             write_i,
    input  logic [Aw-1:0]    addr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Width-1:0] wmask_i,
    output logic             rvalid_o,
    output logic [Width-1:0] rdata_o,
    output logic             rerror_o,
    output logic             werror_o,
    input  ram_1p_cfg_t      cfg_i
);

    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    init_state_e      r_state;
    logic [Aw-1:0]    r_cnt;
    logic             r_done;
    logic             r_rd_vld;
    logic             r_rd_err;
    logic             r_werr;

    logic             w_init;
    logic             w_gnt;
    logic             w_in_range;
    logic             w_rd_gnt;
    logic             w_mem_req;
    logic             w_mem_write;
    logic [Aw-1:0]    w_mem_addr;
    logic [Width-1:0] w_mem_wdata;
    logic [Width-1:0] w_mem_wmask;
    logic [Width-1:0] w_mem_rdata;
    logic [Width-1:0] w_rd_data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= RESET;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                RESET: begin
                    r_cnt <= '0;
                    if (InitOnReset != 0) begin
                        r_state <= INIT;
                    end else begin
                        r_state <= READY;
                        r_done  <= 1'b1;
                    end
                end
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LastAddr) begin
                        r_state <= READY;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                READY: begin
                    if (init_req_i) begin
                        r_state <= INIT;
                        r_done  <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= RESET;
                end
            endcase
        end
    end

    assign w_init = (r_state == INIT);
    assign w_gnt  = (r_state == READY) & req_i & ~init_req_i;

    // With a power-of-two depth every address is valid.
    if ((2 ** Aw) == Depth) begin : gen_rng_full
        assign w_in_range = 1'b1;
    end else begin : gen_rng_chk
        assign w_in_range = (addr_i <= LastAddr);
    end

    assign w_rd_gnt    = w_gnt & ~write_i;
    assign w_mem_req   = w_init | (w_gnt & w_in_range);
    assign w_mem_write = w_init | write_i;
    assign w_mem_addr  = w_init ? r_cnt : addr_i;
    assign w_mem_wdata = w_init ? InitValue : wdata_i;
    assign w_mem_wmask = w_init ? {Width{1'b1}} : wmask_i;

    prim_ram_1p #(
        .Width           (Width),
        .Depth           (Depth),
        .DataBitsPerMask (DataBitsPerMask)
    ) u_ram (
        .i_clk   (clk_i),
        .i_req   (w_mem_req),
        .i_write (w_mem_write),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .i_wmask (w_mem_wmask),
        .o_rdata (w_mem_rdata),
        .i_cfg   (cfg_i)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rd_vld <= 1'b0;
            r_rd_err <= 1'b0;
            r_werr   <= 1'b0;
        end else begin
            r_rd_vld <= w_rd_gnt;
            r_rd_err <= w_rd_gnt & ~w_in_range;
            r_werr   <= w_gnt & write_i & ~w_in_range;
        end
    end

    // Out-of-range reads never enabled the macro, so mask its stale data.
    assign w_rd_data = r_rd_err ? '0 : w_mem_rdata;

    if (OutputReg != 0) begin : gen_oreg
        logic             r_q_vld;
        logic             r_q_err;
        logic [Width-1:0] r_q_data;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_q_vld  <= 1'b0;
                r_q_err  <= 1'b0;
                r_q_data <= '0;
            end else begin
                r_q_vld <= r_rd_vld;
                r_q_err <= r_rd_vld & r_rd_err;
                if (r_rd_vld) begin
                    r_q_data <= w_rd_data;
                end
            end
        end

        assign rvalid_o = r_q_vld;
        assign rerror_o = r_q_err;
        assign rdata_o  = r_q_data;
    end else begin : gen_noreg
        logic [Width-1:0] r_hold;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_hold <= '0;
            end else if (r_rd_vld) begin
                r_hold <= w_rd_data;
            end
        end

        assign rvalid_o = r_rd_vld;
        assign rerror_o = r_rd_vld & r_rd_err;
        assign rdata_o  = r_rd_vld ? w_rd_data : r_hold;
    end

    assign gnt_o       = w_gnt;
    assign init_done_o = r_done;
    assign werror_o    = r_werr;

endmodule
